// File: rtl/cmd_arbiter.sv
// Two-source buffered command arbiter feeding the VGA command port: per-source FIFOs,
// round-robin service and a valid/ready output. Escape-sequence locking is built with CMD_ARB_SEQ_LOCK_EN.
`timescale 1ns/1ps

module cmd_arbiter #(
    parameter int FIFO_AW = 2
`ifdef CMD_ARB_SEQ_LOCK_EN
    ,
    parameter int LOCK_TIMEOUT = 4095
`endif
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] d0,
    input  logic       d0v,
    input  logic [7:0] d1,
    input  logic       d1v,
    output logic [7:0] od,
    output logic       odv,
    input  logic       ordy,
    output logic       locked,
    output logic       lockSrc,
    output logic [1:0] ovf,
    output logic       tout,
    input  logic       errClr
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    logic [7:0]         mem  [2][DEPTH];
    logic [FIFO_AW-1:0] wptr [2];
    logic [FIFO_AW-1:0] rptr [2];
    logic [FIFO_AW:0]   cnt  [2];
    logic [7:0]         din  [2];
    logic [7:0]         head [2];

    logic [1:0] dv;
    logic [1:0] empty;
    logic [1:0] full;
    logic [1:0] elig;
    logic [1:0] req;
    logic [1:0] pop;
    logic [1:0] push;
    logic [1:0] ovf_set;
    logic       load_en;
    logic       do_pop;
    logic       sel;
    logic       last;
    logic [7:0] pop_byte;

    assign dv     = {d1v, d0v};
    assign din[0] = d0;
    assign din[1] = d1;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            empty[s] = (cnt[s] == '0);
            full[s]  = (cnt[s] == FULL_CNT);
            head[s]  = mem[s][rptr[s]];
        end
    end

    // Output handshake: od/odv are held until a clk edge sees odv & ordy; a new byte may be
    // loaded on that same edge, or on any edge where odv is low.
    always_comb begin
        elig = 2'b11;
        if (locked) begin
            elig = lockSrc ? 2'b10 : 2'b01;
        end
        req      = elig & ~empty;
        load_en  = !odv || ordy;
        sel      = (req == 2'b11) ? ~last : req[1];
        do_pop   = load_en && (req != 2'b00);
        pop      = do_pop ? (sel ? 2'b10 : 2'b01) : 2'b00;
        pop_byte = head[sel];
        // A pop frees a slot in the same edge, so a full FIFO can still accept a push.
        push     = dv & (~full | pop);
        ovf_set  = dv & full & ~pop;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < 2; s++) begin
                wptr[s] <= '0;
                rptr[s] <= '0;
                cnt[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    wptr[s] <= wptr[s] + 1'b1;
                end
                if (pop[s]) begin
                    rptr[s] <= rptr[s] + 1'b1;
                end
                case ({push[s], pop[s]})
                    2'b10:   cnt[s] <= cnt[s] + 1'b1;
                    2'b01:   cnt[s] <= cnt[s] - 1'b1;
                    default: cnt[s] <= cnt[s];
                endcase
            end
        end
    end

    // Storage carries no reset; emptiness is defined by the pointers and counts alone.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                mem[s][wptr[s]] <= din[s];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            od   <= '0;
            odv  <= 1'b0;
            last <= 1'b1;
            ovf  <= 2'b00;
        end else begin
            if (do_pop) begin
                od   <= pop_byte;
                odv  <= 1'b1;
                last <= sel;
            end else if (odv && ordy) begin
                odv <= 1'b0;
            end
            for (int s = 0; s < 2; s++) begin
                if (ovf_set[s]) begin
                    ovf[s] <= 1'b1;
                end else if (errClr) begin
                    ovf[s] <= 1'b0;
                end
            end
        end
    end

`ifdef CMD_ARB_SEQ_LOCK_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ESC  = 2'd1,
        ST_CSI  = 2'd2
    } lock_state_t;

    localparam logic [11:0] TMO_LAST = 12'(LOCK_TIMEOUT - 1);

    lock_state_t state;
    lock_state_t state_next;
    logic        src_q;
    logic        src_next;
    logic [11:0] tmo_cnt;
    logic [11:0] tmo_next;
    logic        tout_q;
    logic        tout_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            src_q   <= 1'b0;
            tmo_cnt <= '0;
            tout_q  <= 1'b0;
        end else begin
            state   <= state_next;
            src_q   <= src_next;
            tmo_cnt <= tmo_next;
            tout_q  <= tout_next;
        end
    end

    always_comb begin
        state_next = state;
        src_next   = src_q;
        tmo_next   = tmo_cnt;
        tout_next  = 1'b0;
        if (do_pop) begin
            tmo_next = '0;
            case (state)
                ST_IDLE: begin
                    if (pop_byte == 8'h1B) begin
                        state_next = ST_ESC;
                        src_next   = sel;
                    end
                end
                ST_ESC: begin
                    state_next = (pop_byte == 8'h5B) ? ST_CSI : ST_IDLE;
                end
                ST_CSI: begin
                    // Parameter/intermediate bytes keep the sequence open; anything else ends it.
                    if (pop_byte < 8'h20 || pop_byte > 8'h3F) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (state != ST_IDLE && empty[src_q]) begin
            if (tmo_cnt == TMO_LAST) begin
                state_next = ST_IDLE;
                tmo_next   = '0;
                tout_next  = 1'b1;
            end else begin
                tmo_next = tmo_cnt + 12'd1;
            end
        end else if (state == ST_IDLE) begin
            tmo_next = '0;
        end
        if (state_next == ST_IDLE) begin
            src_next = 1'b0;
        end
    end

    assign locked  = (state != ST_IDLE);
    assign lockSrc = src_q;
    assign tout    = tout_q;
`else
    assign locked  = 1'b0;
    assign lockSrc = 1'b0;
    assign tout    = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_arbiter.sv
// Scoreboard bench for cmd_arbiter: directed stimulus pushes expected bytes, a forked monitor
// pops and compares on every accepted output transfer.
`timescale 1ns/1ps

module tb_cmd_arbiter;
    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] d0;
    logic       d0v;
    logic [7:0] d1;
    logic       d1v;
    logic [7:0] od;
    logic       odv;
    logic       ordy;
    logic       locked;
    logic       lockSrc;
    logic [1:0] ovf;
    logic       tout;
    logic       errClr;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    cmd_arbiter dut (
        .clk(clk), .resetn(resetn),
        .d0(d0), .d0v(d0v), .d1(d1), .d1v(d1v),
        .od(od), .odv(odv), .ordy(ordy),
        .locked(locked), .lockSrc(lockSrc),
        .ovf(ovf), .tout(tout), .errClr(errClr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        d0v    = 1'b0;
        d1v    = 1'b0;
        errClr = 1'b0;
    endtask

    task automatic monitor();
        logic [7:0] held_od;
        bit         held;
        held    = 1'b0;
        held_od = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("odv_held", odv, 1);
                    check("od_stable", od, held_od);
                end
                if (odv && ordy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got 0x%0h, expected no transfer", od);
                    end else begin
                        check("scoreboard_od", od, exp_q.pop_front());
                    end
                end
                held    = odv && !ordy;
                held_od = od;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit seen;
        resetn = 1'b0;
        d0 = '0; d0v = 1'b0; d1 = '0; d1v = 1'b0;
        ordy = 1'b1; errClr = 1'b0;
        fork
            monitor();
        join_none

        // reset state
        #12;
        check("reset_od", od, 0);
        check("reset_odv", odv, 0);
        check("reset_locked", locked, 0);
        check("reset_locksrc", lockSrc, 0);
        check("reset_ovf", ovf, 0);
        check("reset_tout", tout, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // simultaneous strobes, round-robin starts at source 0
        exp_q.push_back(8'h30); exp_q.push_back(8'h31);
        exp_q.push_back(8'h32); exp_q.push_back(8'h33);
        d0 = 8'h30; d0v = 1'b1; d1 = 8'h31; d1v = 1'b1;
        tick();
        d0 = 8'h32; d0v = 1'b1; d1 = 8'h33; d1v = 1'b1;
        tick();
        repeat (6) tick();

        // single byte latency
        exp_q.push_back(8'h41);
        d0 = 8'h41; d0v = 1'b1;
        tick();
        @(negedge clk);
        check("lat_early_odv", odv, 0);
        @(negedge clk);
        check("lat_odv", odv, 1);
        check("lat_od", od, 8'h41);
        @(negedge clk);
        check("lat_drain_odv", odv, 0);
        check("lat_ovf", ovf, 0);
        tick();

        // escape sequence on source 0 with source 1 interleaved
`ifdef CMD_ARB_SEQ_LOCK_EN
        exp_q.push_back(8'h1B); exp_q.push_back(8'h5B); exp_q.push_back(8'h32);
        exp_q.push_back(8'h4A); exp_q.push_back(8'h61); exp_q.push_back(8'h62);
`else
        exp_q.push_back(8'h1B); exp_q.push_back(8'h61); exp_q.push_back(8'h5B);
        exp_q.push_back(8'h62); exp_q.push_back(8'h32); exp_q.push_back(8'h4A);
`endif
        for (int c = 0; c < 14; c++) begin
            case (c)
                0: begin d0 = 8'h1B; d0v = 1'b1; end
                1: begin d1 = 8'h61; d1v = 1'b1; end
                3: begin d0 = 8'h5B; d0v = 1'b1; end
                4: begin d1 = 8'h62; d1v = 1'b1; end
                6: begin d0 = 8'h32; d0v = 1'b1; end
                9: begin d0 = 8'h4A; d0v = 1'b1; end
                default: ;
            endcase
            tick();
            @(negedge clk);
`ifdef CMD_ARB_SEQ_LOCK_EN
            check("lock_locked", locked, (c >= 1 && c <= 9));
`else
            check("lock_locked", locked, 0);
`endif
            check("lock_src", lockSrc, 0);
        end

        // backpressure, overflow, sticky flag and clear
        tick();
        ordy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            d1 = 8'(c + 1); d1v = 1'b1;
            if (c < 5) exp_q.push_back(8'(c + 1));
            tick();
            @(negedge clk);
            if (c == 4) check("ovf_at_full", ovf, 2'b00);
            if (c == 5) begin
                check("ovf_drop", ovf, 2'b10);
                check("bp_od", od, 8'h01);
                check("bp_odv", odv, 1);
            end
        end
        errClr = 1'b1; d1 = 8'h07; d1v = 1'b1;
        tick();
        @(negedge clk);
        check("ovf_set_wins", ovf, 2'b10);
        errClr = 1'b1;
        tick();
        @(negedge clk);
        check("ovf_clear", ovf, 2'b00);
        tick();
        ordy = 1'b1;
        d1 = 8'h08; d1v = 1'b1;
        exp_q.push_back(8'h08);
        tick();
        @(negedge clk);
        check("ovf_full_pushpop", ovf, 2'b00);
        repeat (8) tick();

        // lock timeout
        exp_q.push_back(8'h1B); exp_q.push_back(8'h78);
        d0 = 8'h1B; d0v = 1'b1;
        tick();
        d1 = 8'h78; d1v = 1'b1;
        tick();
        @(negedge clk);
        check("to_first_od", od, 8'h1B);
        check("to_locksrc", lockSrc, 0);
`ifdef CMD_ARB_SEQ_LOCK_EN
        check("to_locked", locked, 1);
        n = 0;
        for (int i = 1; i <= 5000; i++) begin
            @(negedge clk);
            if (tout) begin
                n = i;
                break;
            end
        end
        check("timeout_cycles", n, 4095);
        check("to_unlocked", locked, 0);
        @(negedge clk);
        check("tout_one_cycle", tout, 0);
        check("to_released_od", od, 8'h78);
        check("to_released_odv", odv, 1);
`else
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tout || locked) seen = 1'b1;
        end
        check("tout_never", seen, 0);
`endif
        tick();
        repeat (4) tick();

        // asynchronous reset with a sequence open and bytes buffered
        ordy = 1'b0;
        d1 = 8'h1B; d1v = 1'b1;
        tick();
        d1 = 8'h5B; d1v = 1'b1;
        tick();
        d0 = 8'h55; d0v = 1'b1;
        tick();
        @(negedge clk);
        check("pre_rst_od", od, 8'h1B);
`ifdef CMD_ARB_SEQ_LOCK_EN
        check("pre_rst_locked", locked, 1);
        check("pre_rst_locksrc", lockSrc, 1);
`else
        check("pre_rst_locked", locked, 0);
        check("pre_rst_locksrc", lockSrc, 0);
`endif
        #2;
        resetn = 1'b0;
        #1;
        check("rst_od", od, 0);
        check("rst_odv", odv, 0);
        check("rst_locked", locked, 0);
        check("rst_locksrc", lockSrc, 0);
        check("rst_ovf", ovf, 0);
        check("rst_tout", tout, 0);
        ordy = 1'b1;
        @(negedge clk);
        #2;
        resetn = 1'b1;
        tick();
        exp_q.push_back(8'h41);
        d1 = 8'h41; d1v = 1'b1;
        tick();
        @(negedge clk);
        check("post_rst_early_odv", odv, 0);
        @(negedge clk);
        check("post_rst_odv", odv, 1);
        check("post_rst_od", od, 8'h41);
        check("post_rst_locked", locked, 0);
        tick();
        repeat (4) tick();

        check("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
